// File: rtl/draw_pkg.sv
// draw_pkg: shared state encoding and VGA field widths for the draw scheduler
package draw_pkg;
  typedef enum logic [1:0] {IDLE, MAP, SPR, FIN} state_t;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 6;
endpackage

// File: rtl/draw_priority_pick.sv
// draw_priority_pick: one-hot of the lowest set bit of mask, plus any-set flag
module draw_priority_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] mask,
  output logic [N-1:0] onehot,
  output logic         valid
);
  assign onehot = mask & (~mask + N'(1));
  assign valid = |mask;
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame map/sprite sequencer and VGA write-port arbiter
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int N_SPR = 3,
  parameter int WATCHDOG = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 map_enable,
  input  logic                 map_done,
  input  logic [X_W-1:0]       map_x,
  input  logic [Y_W-1:0]       map_y,
  input  logic [C_W-1:0]       map_colour,
  input  logic                 map_write,
  input  logic [N_SPR-1:0]     spr_req,
  output logic [N_SPR-1:0]     spr_enable,
  input  logic [N_SPR-1:0]     spr_done,
  input  logic [X_W*N_SPR-1:0] spr_x,
  input  logic [Y_W*N_SPR-1:0] spr_y,
  input  logic [C_W*N_SPR-1:0] spr_colour,
  input  logic [N_SPR-1:0]     spr_write,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_write,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout_err
);
  localparam int WD_W = $clog2(WATCHDOG + 1);
  state_t state;
  logic pending;
  logic [N_SPR-1:0] spr_mask, pick;
  logic pick_valid, grant_done, expire;
  logic [WD_W-1:0] wd_cnt;
  draw_priority_pick #(.N(N_SPR)) u_pick (
    .mask(spr_mask),
    .onehot(pick),
    .valid(pick_valid)
  );
  assign grant_done = map_enable ? map_done : |(spr_done & spr_enable);
  assign expire = wd_cnt == WD_W'(WATCHDOG - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      map_enable <= 1'b0;
      spr_enable <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      pending <= 1'b0;
      spr_mask <= '0;
      wd_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
      end
      case (state)
        IDLE: if (frame_start || pending) begin
          spr_mask <= spr_req;
          pending <= 1'b0;
          map_enable <= 1'b1;
          busy <= 1'b1;
          wd_cnt <= '0;
          state <= MAP;
        end
        MAP, SPR: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          // a watchdog expiry is handled exactly like done, just flagged
          if (grant_done || expire) begin
            map_enable <= 1'b0;
            spr_enable <= pick;
            spr_mask <= spr_mask & ~pick;
            wd_cnt <= '0;
            if (!grant_done) timeout_err <= 1'b1;
            state <= pick_valid ? SPR : FIN;
          end
        end
        FIN: begin
          frame_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    vga_x = map_enable ? map_x : '0;
    vga_y = map_enable ? map_y : '0;
    vga_colour = map_enable ? map_colour : '0;
    vga_write = map_enable & map_write;
    for (int i = 0; i < N_SPR; i++)
      if (spr_enable[i]) begin
        vga_x = spr_x[X_W*i +: X_W];
        vga_y = spr_y[Y_W*i +: Y_W];
        vga_colour = spr_colour[C_W*i +: C_W];
        vga_write = spr_write[i];
      end
  end
endmodule
